life_grid_scheduler: RTL and testbench

- Owns the single-port cell RAM behind the life game and sequences generations.
- Shares the RAM between three users: the video fetch path, the cursor/edit path driven by the buttons, and the next-generation compute engine.
- The RAM is ping-ponged in two banks. The scheduler starts one engine pass per step tick, swaps banks on completion, and provides a hardware grid-clear sweep.
- Sits between the debounced switch/button logic, the VGA pixel path and the cell RAM.

---
 rtl/life_grid_scheduler_pkg.sv | 17 +
 rtl/life_grid_arbiter.sv | 50 +++++
 rtl/life_grid_scheduler.sv | 141 ++++++++++++++
 tb/tb_life_grid_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_grid_scheduler_pkg.sv
// Shared constants and state encoding for the life grid scheduler, core and video path.
package life_grid_scheduler_pkg;

  localparam int unsigned GridW         = 32;
  localparam int unsigned GridH         = 24;
  localparam int unsigned GridCellAw    = 10;
  localparam int unsigned GridCellCount = GridW * GridH;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StRun   = 3'd2,
    StSwap  = 3'd3,
    StClear = 3'd4
  } sched_state_e;

endpackage

// File: rtl/life_grid_arbiter.sv
// Fixed-priority grant for the cell RAM plus 1-cycle read-valid routing back to requesters.
module life_grid_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vid_req_i,
  input  logic edit_req_i,
  input  logic edit_we_i,
  input  logic edit_en_i,
  input  logic eng_req_i,
  input  logic eng_we_i,
  input  logic eng_en_i,
  input  logic sweep_req_i,
  output logic vid_gnt_o,
  output logic edit_gnt_o,
  output logic eng_gnt_o,
  output logic sweep_gnt_o,
  output logic mem_en_o,
  output logic vid_rvalid_o,
  output logic edit_rvalid_o,
  output logic eng_rvalid_o
);

  logic vid_rvalid_q, edit_rvalid_q, eng_rvalid_q;

  // Video always wins so the pixel stream never stalls.
  always_comb begin
    vid_gnt_o   = vid_req_i;
    edit_gnt_o  = edit_req_i & edit_en_i & ~vid_req_i;
    eng_gnt_o   = eng_req_i & eng_en_i & ~vid_req_i;
    sweep_gnt_o = sweep_req_i & ~vid_req_i;
    mem_en_o    = vid_gnt_o | edit_gnt_o | eng_gnt_o | sweep_gnt_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vid_rvalid_q  <= 1'b0;
      edit_rvalid_q <= 1'b0;
      eng_rvalid_q  <= 1'b0;
    end else begin
      vid_rvalid_q  <= vid_gnt_o;
      edit_rvalid_q <= edit_gnt_o & ~edit_we_i;
      eng_rvalid_q  <= eng_gnt_o & ~eng_we_i;
    end
  end

  assign vid_rvalid_o  = vid_rvalid_q;
  assign edit_rvalid_o = edit_rvalid_q;
  assign eng_rvalid_o  = eng_rvalid_q;

endmodule

// File: rtl/life_grid_scheduler.sv
// Generation sequencer and cell RAM owner: ping-pong banks, engine handshake, clear sweep.
module life_grid_scheduler
  import life_grid_scheduler_pkg::*;
#(
  parameter int unsigned CELL_AW    = GridCellAw,
  parameter int unsigned CELL_COUNT = GridCellCount,
  parameter int unsigned OVR_W      = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               step_tick,
  input  logic               pause,
  input  logic               single_step,
  input  logic               clear_req,
  input  logic               vid_req,
  input  logic [CELL_AW-1:0] vid_addr,
  output logic               vid_rvalid,
  input  logic               edit_req,
  input  logic               edit_we,
  input  logic [CELL_AW-1:0] edit_addr,
  input  logic               edit_wdata,
  output logic               edit_gnt,
  output logic               edit_rvalid,
  input  logic               eng_req,
  input  logic               eng_we,
  input  logic [CELL_AW-1:0] eng_addr,
  input  logic               eng_wdata,
  output logic               eng_gnt,
  output logic               eng_rvalid,
  output logic               step_start,
  input  logic               step_done,
  output logic               mem_en,
  output logic               mem_we,
  output logic [CELL_AW:0]   mem_addr,
  output logic               mem_wdata,
  output logic               bank,
  output logic               busy,
  output logic [15:0]        generation,
  output logic [OVR_W-1:0]   overrun_cnt
);

  sched_state_e       state_q, state_d;
  logic               bank_q;
  logic [15:0]        gen_q;
  logic [OVR_W-1:0]   ovr_q;
  logic [CELL_AW-1:0] cnt_q;
  logic               step_start_q;
  logic               vid_gnt, sweep_gnt;
  logic               go_step, any_evt;

  assign go_step = (step_tick & ~pause) | single_step;
  assign any_evt = go_step | clear_req;

  life_grid_arbiter u_arbiter (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .vid_req_i     (vid_req),
    .edit_req_i    (edit_req),
    .edit_we_i     (edit_we),
    .edit_en_i     (state_q == StIdle),
    .eng_req_i     (eng_req),
    .eng_we_i      (eng_we),
    .eng_en_i      (state_q == StRun),
    .sweep_req_i   (state_q == StClear),
    .vid_gnt_o     (vid_gnt),
    .edit_gnt_o    (edit_gnt),
    .eng_gnt_o     (eng_gnt),
    .sweep_gnt_o   (sweep_gnt),
    .mem_en_o      (mem_en),
    .vid_rvalid_o  (vid_rvalid),
    .edit_rvalid_o (edit_rvalid),
    .eng_rvalid_o  (eng_rvalid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req)    state_d = StClear;
        else if (go_step) state_d = StStart;
      end
      StStart: state_d = StRun;
      StRun:   if (step_done) state_d = StSwap;
      StSwap:  state_d = StIdle;
      StClear: if (sweep_gnt && cnt_q == CELL_AW'(CELL_COUNT - 1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 1'b0;
    if (vid_gnt) begin
      mem_addr = {bank_q, vid_addr};
    end else if (edit_gnt) begin
      mem_we    = edit_we;
      mem_addr  = {bank_q, edit_addr};
      mem_wdata = edit_wdata;
    end else if (eng_gnt) begin
      // Engine reads the displayed bank and writes the next one.
      mem_we    = eng_we;
      mem_addr  = {bank_q ^ eng_we, eng_addr};
      mem_wdata = eng_wdata;
    end else if (sweep_gnt) begin
      mem_we   = 1'b1;
      mem_addr = {bank_q, cnt_q};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bank_q       <= 1'b0;
      gen_q        <= '0;
      ovr_q        <= '0;
      cnt_q        <= '0;
      step_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_start_q <= (state_q == StStart);
      if (state_q == StSwap) begin
        bank_q <= ~bank_q;
        gen_q  <= gen_q + 16'd1;
      end
      if (state_q == StClear && sweep_gnt) begin
        cnt_q <= (state_d == StIdle) ? '0 : cnt_q + 1'b1;
      end
      if (any_evt && state_q != StIdle && ovr_q != '1) begin
        ovr_q <= ovr_q + 1'b1;
      end
    end
  end

  assign step_start  = step_start_q;
  assign bank        = bank_q;
  assign busy        = (state_q != StIdle);
  assign generation  = gen_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_life_grid_scheduler.sv
// Scoreboarded bench: expected RAM writes are queued at stimulus time and popped by a monitor.
module tb_life_grid_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_tick = 0, pause = 0, single_step = 0, clear_req = 0;
  logic        vid_req = 0;
  logic [9:0]  vid_addr = '0;
  logic        vid_rvalid;
  logic        edit_req = 0, edit_we = 0, edit_wdata = 0;
  logic [9:0]  edit_addr = '0;
  logic        edit_gnt, edit_rvalid;
  logic        eng_req = 0, eng_we = 0, eng_wdata = 0;
  logic [9:0]  eng_addr = '0;
  logic        eng_gnt, eng_rvalid;
  logic        step_start;
  logic        step_done = 0;
  logic        mem_en, mem_we, mem_wdata;
  logic [10:0] mem_addr;
  logic        bank, busy;
  logic [15:0] generation;
  logic [7:0]  overrun_cnt;

  typedef struct packed {
    logic [10:0] addr;
    logic        data;
  } wr_t;

  wr_t  wq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic vid_prev;

  always #5 clock = ~clock;

  life_grid_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .step_tick   (step_tick),
    .pause       (pause),
    .single_step (single_step),
    .clear_req   (clear_req),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_rvalid  (vid_rvalid),
    .edit_req    (edit_req),
    .edit_we     (edit_we),
    .edit_addr   (edit_addr),
    .edit_wdata  (edit_wdata),
    .edit_gnt    (edit_gnt),
    .edit_rvalid (edit_rvalid),
    .eng_req     (eng_req),
    .eng_we      (eng_we),
    .eng_addr    (eng_addr),
    .eng_wdata   (eng_wdata),
    .eng_gnt     (eng_gnt),
    .eng_rvalid  (eng_rvalid),
    .step_start  (step_start),
    .step_done   (step_done),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .bank        (bank),
    .busy        (busy),
    .generation  (generation),
    .overrun_cnt (overrun_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference for video read latency: valid one cycle after the request.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) vid_prev <= 1'b0;
    else          vid_prev <= vid_req;
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check_eq("vid_rvalid", {31'd0, vid_rvalid}, {31'd0, vid_prev});
      if (mem_en && mem_we) begin
        if (wq.size() == 0) begin
          check_eq("wr_unexpected", {31'd0, mem_we}, 32'd0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check_eq("wr_addr", {21'd0, mem_addr}, {21'd0, e.addr});
          check_eq("wr_data", {31'd0, mem_wdata}, {31'd0, e.data});
        end
      end
    end
  end

  initial begin
    int n;
    logic saw_start;

    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    cyc();
    #1;
    check_eq("rst_bank", {31'd0, bank}, 0);
    check_eq("rst_gen", {16'd0, generation}, 0);
    check_eq("rst_ovr", {24'd0, overrun_cnt}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_start", {31'd0, step_start}, 0);
    check_eq("rst_mem_en", {31'd0, mem_en}, 0);

    // Step tick -> START -> step_start pulse two cycles after the tick.
    step_tick = 1;
    cyc(); step_tick = 0; #1;
    check_eq("start_busy", {31'd0, busy}, 1);
    check_eq("start_early", {31'd0, step_start}, 0);
    cyc(); #1;
    check_eq("start_pulse", {31'd0, step_start}, 1);
    cyc();
    check_eq("start_once", {31'd0, step_start}, 0);

    // Engine write goes to the next bank, engine read to the current bank.
    eng_req = 1; eng_we = 1; eng_addr = 10'd5; eng_wdata = 1;
    wq.push_back('{addr: 11'h405, data: 1'b1});
    #1;
    check_eq("eng_wr_gnt", {31'd0, eng_gnt}, 1);
    check_eq("eng_wr_addr", {21'd0, mem_addr}, 32'h405);
    cyc(); eng_we = 0; eng_addr = 10'd7; #1;
    check_eq("eng_rd_addr", {21'd0, mem_addr}, 32'h007);
    cyc(); eng_req = 0; #1;
    check_eq("eng_rvalid", {31'd0, eng_rvalid}, 1);
    check_eq("edit_rvalid0", {31'd0, edit_rvalid}, 0);

    // Video always beats the engine.
    eng_req = 1; eng_we = 1; eng_addr = 10'd9; eng_wdata = 1;
    for (int i = 0; i < 4; i++) begin
      vid_req = 1; vid_addr = 10'(20 + i); #1;
      check_eq("eng_blocked", {31'd0, eng_gnt}, 0);
      check_eq("vid_addr", {21'd0, mem_addr}, {22'd0, vid_addr});
      cyc();
    end
    vid_req = 0;
    wq.push_back('{addr: 11'h409, data: 1'b1});
    #1;
    check_eq("eng_regrant", {31'd0, eng_gnt}, 1);
    cyc(); eng_req = 0; eng_we = 0;

    // Editor held off until the scheduler returns to IDLE.
    edit_req = 1; edit_we = 1; edit_addr = 10'd3; edit_wdata = 1; #1;
    check_eq("edit_run", {31'd0, edit_gnt}, 0);
    cyc(); step_done = 1; #1;
    check_eq("edit_run2", {31'd0, edit_gnt}, 0);
    cyc(); step_done = 0; #1;
    check_eq("edit_swap", {31'd0, edit_gnt}, 0);
    cyc();
    wq.push_back('{addr: 11'h403, data: 1'b1});
    #1;
    check_eq("edit_idle", {31'd0, edit_gnt}, 1);
    check_eq("edit_addr", {21'd0, mem_addr}, 32'h403);
    check_eq("gen1_bank", {31'd0, bank}, 1);
    check_eq("gen1_gen", {16'd0, generation}, 1);
    cyc(); edit_req = 0; edit_we = 0;

    // Clear sweep, video idle, then again with 10 injected video cycles.
    for (int pass = 0; pass < 2; pass++) begin
      clear_req = 1;
      for (int a = 0; a < 768; a++) wq.push_back('{addr: {1'b1, 10'(a)}, data: 1'b0});
      cyc(); clear_req = 0;
      n = 0;
      while (busy && n < 2000) begin
        n++;
        vid_req  = (pass == 1) && (n >= 100) && (n < 110);
        vid_addr = 10'(n);
        cyc();
      end
      vid_req = 0;
      check_eq(pass == 0 ? "sweep_len" : "sweep_len_vid", n, pass == 0 ? 768 : 778);
      check_eq("sweep_drain", wq.size(), 0);
      wq.delete();
    end

    // Paused ticks are ignored; single_step still runs one generation.
    pause = 1;
    saw_start = 0;
    for (int i = 0; i < 3; i++) begin
      step_tick = 1; cyc(); step_tick = 0;
      for (int k = 0; k < 3; k++) begin
        #1; if (step_start || busy) saw_start = 1;
        cyc();
      end
    end
    check_eq("pause_no_start", {31'd0, saw_start}, 0);
    single_step = 1; cyc(); single_step = 0; cyc(); #1;
    check_eq("single_start", {31'd0, step_start}, 1);
    step_done = 1; cyc(); step_done = 0; cyc(); cyc(); #1;
    check_eq("single_gen", {16'd0, generation}, 2);
    check_eq("single_bank", {31'd0, bank}, 0);
    check_eq("single_idle", {31'd0, busy}, 0);
    pause = 0;

    // Lost ticks during a long RUN saturate the overrun counter.
    step_tick = 1; cyc(); step_tick = 0; cyc(); cyc();
    for (int i = 0; i < 300; i++) begin
      step_tick = 1; cyc();
    end
    step_tick = 0; #1;
    check_eq("ovr_sat", {24'd0, overrun_cnt}, 255);
    check_eq("ovr_busy", {31'd0, busy}, 1);

    // Asynchronous reset mid-RUN.
    #2 reset_n = 0; #1;
    check_eq("arst_busy", {31'd0, busy}, 0);
    check_eq("arst_gen", {16'd0, generation}, 0);
    check_eq("arst_ovr", {24'd0, overrun_cnt}, 0);
    check_eq("arst_bank", {31'd0, bank}, 0);
    check_eq("arst_start", {31'd0, step_start}, 0);
    check_eq("arst_vid_rvalid", {31'd0, vid_rvalid}, 0);
    check_eq("arst_mem_en", {31'd0, mem_en}, 0);
    cyc(); reset_n = 1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
